// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared state encoding and default sizes for the class-FIFO drain arbiter.
// The size defaults match the per-class fifo instances feeding this block.
package fifo_drain_arbiter_pkg;

  localparam int DATA_SIZE_DEF  = 6;
  localparam int NUM_QUEUES_DEF = 4;
  localparam int SEL_W_DEF      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSE  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_drain_arbiter_rr_grant.sv
// Combinational grant picker for the drain arbiter: round-robin by default,
// fixed lowest-index-first priority when STRICT_PRIORITY_EN is defined.
module fifo_drain_arbiter_rr_grant #(
  parameter int NUM_QUEUES = 4,
  parameter int SEL_W      = 2
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [SEL_W-1:0]      last_grant,
  output logic [NUM_QUEUES-1:0] grant,
  output logic [SEL_W-1:0]      grant_idx,
  output logic                  any_req
);

  logic             found;
  logic [SEL_W-1:0] idx;
  int               pos;

  assign any_req = |req;

`ifdef STRICT_PRIORITY_EN
  logic [SEL_W-1:0] unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    pos       = 0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      pos = i;
      idx = SEL_W'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
`else
  // Search starts just after the previous winner and wraps past the top queue.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    pos       = 0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      pos = int'(last_grant) + i;
      if (pos >= NUM_QUEUES) pos = pos - NUM_QUEUES;
      idx = SEL_W'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains the per-class FIFO bank one word per cycle into a single tagged stream.
// Define STRICT_PRIORITY_EN for fixed priority instead of round-robin.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int NUM_QUEUES = NUM_QUEUES_DEF,
  parameter int SEL_W      = SEL_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic [NUM_QUEUES-1:0]           fifo_empty,
  input  logic [NUM_QUEUES*DATA_SIZE-1:0] fifo_data,
  input  logic                            pause_in,
  output logic [NUM_QUEUES-1:0]           pop,
  output logic [DATA_SIZE-1:0]            data_out,
  output logic                            valid_out,
  output logic [SEL_W-1:0]                sel_out,
  output logic                            active_out
);

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      last_grant_q, last_grant_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DATA_SIZE-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;

  logic [NUM_QUEUES-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic                  any_req;
  logic                  pop_en;
  logic [DATA_SIZE-1:0]  head [NUM_QUEUES];

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_head
    assign head[g] = fifo_data[g*DATA_SIZE +: DATA_SIZE];
  end

  fifo_drain_arbiter_rr_grant #(
    .NUM_QUEUES (NUM_QUEUES),
    .SEL_W      (SEL_W)
  ) u_rr_grant (
    .req        (~fifo_empty),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  // Pause always wins, so a rising pause_in blocks the pop in that same cycle.
  always_comb begin
    state_d = state_q;
    pop_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pause_in)     state_d = PAUSE;
        else if (any_req) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (pause_in)      state_d = PAUSE;
        else if (!any_req) state_d = IDLE;
        else               pop_en  = 1'b1;
      end
      PAUSE: begin
        if (!pause_in) state_d = any_req ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = pop_en ? grant : '0;

  always_comb begin
    data_d       = data_q;
    sel_d        = sel_q;
    valid_d      = pop_en;
    last_grant_d = last_grant_q;
    if (pop_en) begin
      data_d = head[grant_idx];
      sel_d  = grant_idx;
`ifndef STRICT_PRIORITY_EN
      last_grant_d = grant_idx;
`endif
    end
  end

  // Pointer resets to the top queue so the first round-robin search lands on queue 0.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_W'(NUM_QUEUES - 1);
      data_q       <= '0;
      sel_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      valid_q      <= valid_d;
    end
  end

  assign data_out   = data_q;
  assign sel_out    = sel_q;
  assign valid_out  = valid_q;
  assign active_out = (state_q == ACTIVE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Randomised and directed bench for fifo_drain_arbiter against a queue-based
// behavioural model; define STRICT_PRIORITY_EN here too for the strict build.
module tb_fifo_drain_arbiter;

  localparam int DW = 6;
  localparam int NQ = 4;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              reset_L;
  logic [NQ-1:0]     fifo_empty;
  logic [NQ*DW-1:0]  fifo_data;
  logic              pause_in;
  logic [NQ-1:0]     pop;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic [SW-1:0]     sel_out;
  logic              active_out;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq [NQ][$];

  // Model: 0 = idle, 1 = active, 2 = paused.
  int            m_state;
  int            m_last;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_sel;

  always #5 clk = ~clk;

  fifo_drain_arbiter #(
    .DATA_SIZE  (DW),
    .NUM_QUEUES (NQ),
    .SEL_W      (SW)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .pause_in   (pause_in),
    .pop        (pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .sel_out    (sel_out),
    .active_out (active_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NQ; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : DW'($urandom);
    end
  endtask

  function automatic int modelPick();
    for (int k = 1; k <= NQ; k++) begin
`ifdef STRICT_PRIORITY_EN
      int q = k - 1;
`else
      int q = (m_last + k) % NQ;
`endif
      if (fq[q].size() != 0) return q;
    end
    return -1;
  endfunction

  function automatic bit anyWords();
    for (int i = 0; i < NQ; i++) if (fq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    m_state = 0;
    m_last  = NQ - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = '0;
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model.
  task automatic applyStimulus(input bit pz);
    int            g;
    bit            any;
    logic [NQ-1:0] exp_pop;
    pause_in = pz;
    driveInputs();
    #1;
    any = anyWords();
    g = (m_state == 1 && !pz) ? modelPick() : -1;
    exp_pop = '0;
    if (g >= 0) exp_pop[g] = 1'b1;
    checkOutput("pop", pop, exp_pop);
    checkOutput("pop_to_empty", pop & fifo_empty, 0);
    checkOutput("valid_out", valid_out, m_valid);
    checkOutput("data_out", data_out, m_data);
    checkOutput("sel_out", sel_out, m_sel);
    checkOutput("active_out", active_out, m_state == 1);
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = fq[g].pop_front();
      m_sel   = g[SW-1:0];
      m_last  = g;
    end else begin
      m_valid = 1'b0;
    end
    m_state = pz ? 2 : (any ? 1 : 0);
    @(negedge clk);
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic doReset();
    #2 reset_L = 1'b0;
    #1;
    checkOutput("rst_pop", pop, 0);
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_sel", sel_out, 0);
    checkOutput("rst_active", active_out, 0);
    modelReset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L  = 1'b0;
    pause_in = 1'b0;
    modelReset();
    driveInputs();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("idle_pop", pop, 0);
    checkOutput("idle_valid", valid_out, 0);
    checkOutput("idle_active", active_out, 0);
    fq[0].push_back(6'h2A);
    driveInputs();
    #1;
    checkOutput("rst_hold_pop", pop, 0);
    @(negedge clk);
    reset_L = 1'b1;
    repeat (4) applyStimulus(1'b0);

    $display("[TB] single queue stream");
    fq[2].push_back(6'h05);
    fq[2].push_back(6'h0A);
    fq[2].push_back(6'h15);
    repeat (6) applyStimulus(1'b0);

    $display("[TB] round-robin with mid-stream reset");
    for (int i = 0; i < NQ; i++) repeat (2) fq[i].push_back(DW'($urandom));
    repeat (3) applyStimulus(1'b0);
    doReset();
    repeat (10) applyStimulus(1'b0);

    $display("[TB] pause in third stream cycle");
    for (int i = 0; i < NQ; i++) repeat (3) fq[i].push_back(DW'($urandom));
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    repeat (18) applyStimulus(1'b0);

    $display("[TB] empty-queue skip");
    doReset();
    fq[1].push_back(6'h11);
    for (int i = 0; i < 3; i++) fq[3].push_back(DW'(6'h30 + i));
    repeat (8) applyStimulus(1'b0);

    $display("[TB] queues 0 and 3 contend");
    doReset();
    fq[0].push_back(6'h01);
    fq[0].push_back(6'h02);
    fq[3].push_back(6'h33);
    repeat (6) applyStimulus(1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      int q;
      q = $urandom_range(0, NQ - 1);
      if ($urandom_range(0, 99) < 65 && fq[q].size() < 4) fq[q].push_back(DW'($urandom));
      if (n == 150) doReset();
      applyStimulus($urandom_range(0, 99) < 20);
    end
    repeat (20) applyStimulus(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Consumer end of the class FIFOs: pops words from NUM_QUEUES fifo instances and forwards one word per cycle to a single downstream port.
- Observes each FIFO's empty flag and the downstream pause (almost-full) condition.
- Tags each forwarded word with its source queue.
- Sits between the per-class FIFO bank and the downstream mux/FIFO stage.

Parameters:
- DATA_SIZE, 6, width of one FIFO word.
- NUM_QUEUES, 4, number of source FIFOs.
- SEL_W, 2, width of the queue index; must equal clog2(NUM_QUEUES).

Ports:
- clk  input  1  clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- fifo_empty  input  NUM_QUEUES  per-queue empty flag; bit i belongs to queue i.
- fifo_data  input  NUM_QUEUES*DATA_SIZE  head word of each queue, flattened; queue i occupies bits [i*DATA_SIZE +: DATA_SIZE]. Valid in the cycle the matching pop is high.
- pause_in  input  1  downstream pause/almost-full.
- pop  output  NUM_QUEUES  one-hot read strobe to the source FIFOs; combinational.
- data_out  output  DATA_SIZE  forwarded word; registered.
- valid_out  output  1  data_out is valid this cycle; write strobe downstream.
- sel_out  output  SEL_W  source queue index of data_out.
- active_out  output  1  high while the FSM is in ACTIVE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - Registered outputs clear: data_out=0, valid_out=0, sel_out=0.
  - FSM goes to IDLE.
  - Round-robin pointer last_grant = NUM_QUEUES-1, so queue 0 wins first.
- pop is combinational and always 0 in IDLE, in PAUSE, during reset, and in any cycle with pause_in=1.
- FSM states are IDLE, ACTIVE, PAUSE (2-bit encoding):
  - IDLE:
    - pause_in=1 -> PAUSE.
    - Else, any fifo_empty bit = 0 -> ACTIVE.
    - Else stay in IDLE.
  - ACTIVE:
    - pause_in=1 -> pop=0, go to PAUSE.
    - Else, all fifo_empty bits = 1 -> pop=0, go to IDLE.
    - Else grant the first non-empty queue searching upward from last_grant+1 (mod NUM_QUEUES) and assert pop[grant] for one cycle.
    - Update last_grant on that edge.
  - PAUSE:
    - pop=0.
    - pause_in=0 and any queue non-empty -> ACTIVE.
    - pause_in=0 and all queues empty -> IDLE.
- Pop-to-output latency is 1 cycle. On the edge where pop[g]=1:
  - data_out <= fifo_data slice g.
  - sel_out <= g.
  - valid_out <= 1.
- valid_out is 0 on the next edge when no pop occurred; data_out and sel_out hold their last values.
- Throughput is one word per cycle while ACTIVE and unpaused; at most one pop bit high per cycle.
- Pop is never asserted to a queue whose fifo_empty=1 in that cycle. A FIFO going empty the same cycle it is popped is handled by the FIFO; the next cycle's empty flag governs.
- A pause_in rising in a cycle blocks that cycle's pop. The word popped in the previous cycle is still delivered (valid_out=1); downstream almost-full margin must be at least 1.
- Round-robin wrap: after queue NUM_QUEUES-1 the search continues at queue 0.
- A single non-empty queue is popped every cycle.

Optional Feature:
- Macro STRICT_PRIORITY_EN.
- Defined: fixed priority, lowest index wins (queue 0 highest); last_grant is unused and not updated.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package/include holds:
  - state localparams IDLE=2'd0, ACTIVE=2'd1, PAUSE=2'd2;
  - the DATA_SIZE and NUM_QUEUES defaults shared with fifo.
- One natural sub-module: rr_grant.
  - Combinational.
  - Inputs: request vector (~fifo_empty), last_grant.
  - Outputs: one-hot grant, grant index, any_req.
  - The STRICT_PRIORITY_EN switch lives inside it.

Test Plan:
- Reset and idle: hold reset_L=0 with fifo_empty=4'b1111 -> pop=0, valid_out=0, state IDLE. Assert reset_L=0 asynchronously mid-ACTIVE -> outputs clear before the next clk edge.
- Single queue: queue 2 holds 3 words (6'h05, 6'h0A, 6'h15), others empty -> pop=4'b0100 for 3 cycles; valid_out on the following 3 cycles with data 05, 0A, 15 and sel_out=2; then IDLE.
- Round-robin: all 4 queues non-empty -> pop sequence 0001, 0010, 0100, 1000, 0001; sel_out 0, 1, 2, 3, 0, each one cycle after its pop.
- Pause: pause_in=1 during the 3rd cycle of a stream -> that cycle pop=0, valid_out=1 for the word popped before; state PAUSE. pause_in=0 -> pop resumes at the next round-robin queue with no word lost or duplicated.
- Empty boundary: queue 1 popped to empty while queue 3 is non-empty -> the next grant skips 1 and goes to queue 3; no pop to an empty queue, checked by assertion every cycle.
- STRICT_PRIORITY_EN build: queues 0 and 3 non-empty, with 0 holding 2 words -> pop 0001, 0001, 1000.
